pattern_detector_moore: RTL and testbench

PATTERN_DETECTOR_MOORE -- requirements
Module: pattern_detector_moore

---
 rtl/pattern_det_pkg.sv | 18 +
 rtl/prefix_match.sv | 35 +++
 rtl/pattern_detector_moore.sv | 120 ++++++++++++
 tb/tb_pattern_detector_moore.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pattern_det_pkg.sv
// -----------------------------------------------------------------------------
// pattern_det_pkg
// Shared definitions for the serial pattern detector:
//   state_e          - Moore FSM state encoding (IDLE / SEARCH / HIT, 2 bits)
//   PATTERN_DEFAULT  - pattern loaded at reset when no override is given
//                      (MSB is the first bit received)
// -----------------------------------------------------------------------------
package pattern_det_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,   // no pattern bit currently matched
      ST_SEARCH = 2'd1,   // a non-empty pattern prefix is matched
      ST_HIT    = 2'd2    // full pattern accepted on the previous edge
   } state_e;

   localparam logic [4:0] PATTERN_DEFAULT = 5'b11010;

endpackage

// File: rtl/prefix_match.sv
// -----------------------------------------------------------------------------
// prefix_match
// Returns the length of the longest suffix of the valid history bits that
// equals a prefix of the pattern. Only the newest 'fill' bits of history are
// considered valid.
// Ports:
//   history   [W-1:0]      in  - shift history, newest bit at LSB
//   fill      [FILL_W-1:0] in  - number of valid history bits (0..W)
//   pattern   [W-1:0]      in  - pattern, MSB = first bit of the sequence
//   match_len [FILL_W-1:0] out - matched length (0..W)
// -----------------------------------------------------------------------------
module prefix_match #(
   parameter int W      = 5,
   parameter int FILL_W = 3
) (
   input  logic [W-1:0]      history,
   input  logic [W-1:0]      pattern,
   input  logic [FILL_W-1:0] fill,
   output logic [FILL_W-1:0] match_len
);

   // For a candidate length k the suffix is history[k-1:0] and the prefix is
   // pattern[W-1:W-k]; shifting the pattern right aligns the two, and the mask
   // keeps only the low k bits. Later (longer) hits overwrite shorter ones.
   always_comb begin
      match_len = '0;
      for (int k = 1; k <= W; k++) begin
         if ((FILL_W'(k) <= fill) &&
             (((history ^ (pattern >> (W - k))) & ({W{1'b1}} >> (W - k))) == '0)) begin
            match_len = FILL_W'(k);
         end
      end
   end

endmodule

// File: rtl/pattern_detector_moore.sv
// -----------------------------------------------------------------------------
// pattern_detector_moore
// Moore-style serial pattern detector with a runtime-loadable pattern, an
// overlap/non-overlap mode and a saturating match counter.
// Ports:
//   clk_in           in  - clock, all state updates on the rising edge
//   reset            in  - asynchronous, active-low reset
//   data_valid_in    in  - qualifies data_in
//   data_in          in  - serial data bit
//   load_in          in  - synchronous pattern load strobe
//   pattern_in       in  - new pattern [PATTERN_W-1:0], MSB first
//   detected_out     out - high for one cycle after the final pattern bit
//   match_count_out  out - saturating detection count [CNT_W-1:0]
//   busy_out         out - a non-empty pattern prefix is currently matched
//
// Input qualification: data_in is consumed on every rising edge where
// data_valid_in=1 and load_in=0. There is no back-pressure; the block can
// accept a bit every cycle. A load on the same edge discards the data bit.
// -----------------------------------------------------------------------------
module pattern_detector_moore
   import pattern_det_pkg::*;
#(
   parameter int                   PATTERN_W   = 5,
   parameter logic [PATTERN_W-1:0] PATTERN_RST = PATTERN_W'(PATTERN_DEFAULT),
   parameter int                   OVERLAP     = 1,
   parameter int                   CNT_W       = 8
) (
   input  logic                 clk_in,
   input  logic                 reset,
   input  logic                 data_valid_in,
   input  logic                 data_in,
   input  logic                 load_in,
   input  logic [PATTERN_W-1:0] pattern_in,
   output logic                 detected_out,
   output logic [CNT_W-1:0]     match_count_out,
   output logic                 busy_out
);

   localparam int FILL_W = $clog2(PATTERN_W + 1);
   localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PATTERN_W);

   logic [PATTERN_W-1:0] pattern_q;
   logic [PATTERN_W-1:0] history_q;
   logic [FILL_W-1:0]    fill_q;
   logic [CNT_W-1:0]     count_q;
   state_e               state_q;
   state_e               state_d;

   logic [PATTERN_W-1:0] history_nxt;
   logic [FILL_W-1:0]    fill_inc;
   logic [FILL_W-1:0]    len_cur;
   logic [FILL_W-1:0]    len_nxt;
   logic                 accept;
   logic                 detect;

   // Candidate history/fill as they would be after accepting data_in.
   assign history_nxt = {history_q[PATTERN_W-2:0], data_in};
   assign fill_inc    = (fill_q == FILL_FULL) ? fill_q : fill_q + FILL_W'(1);
   assign accept      = data_valid_in && !load_in;
   assign detect      = accept && (fill_inc == FILL_FULL) && (history_nxt == pattern_q);

   // Matched prefix length of the registered history (drives busy_out).
   prefix_match #(.W(PATTERN_W), .FILL_W(FILL_W)) u_match_cur (
      .history   (history_q),
      .pattern   (pattern_q),
      .fill      (fill_q),
      .match_len (len_cur)
   );

   // Matched prefix length after the incoming bit (selects SEARCH vs IDLE).
   prefix_match #(.W(PATTERN_W), .FILL_W(FILL_W)) u_match_nxt (
      .history   (history_nxt),
      .pattern   (pattern_q),
      .fill      (fill_inc),
      .match_len (len_nxt)
   );

   always_comb begin
      state_d = state_q;
      if (load_in) begin
         state_d = ST_IDLE;
      end else if (accept) begin
         if (detect)              state_d = ST_HIT;
         else if (len_nxt != '0)  state_d = ST_SEARCH;
         else                     state_d = ST_IDLE;
      end else if (state_q == ST_HIT) begin
         state_d = ST_IDLE;
      end
   end

   always_ff @(posedge clk_in or negedge reset) begin
      if (!reset) begin
         state_q   <= ST_IDLE;
         pattern_q <= PATTERN_RST;
         history_q <= '0;
         fill_q    <= '0;
         count_q   <= '0;
      end else begin
         state_q <= state_d;
         if (load_in) begin
            pattern_q <= pattern_in;
            history_q <= '0;
            fill_q    <= '0;
         end else if (accept) begin
            history_q <= history_nxt;
            // In non-overlap mode a detection empties the window so that no
            // bit can contribute to a second detection.
            fill_q    <= (detect && (OVERLAP == 0)) ? '0 : fill_inc;
            if (detect && (count_q != {CNT_W{1'b1}})) begin
               count_q <= count_q + CNT_W'(1);
            end
         end
      end
   end

   assign detected_out    = (state_q == ST_HIT);
   assign busy_out        = (len_cur != '0) && (state_q != ST_HIT);
   assign match_count_out = count_q;

endmodule

// File: tb/tb_pattern_detector_moore.sv
// -----------------------------------------------------------------------------
// tb_pattern_detector_moore
// Four detector instances with different parameters share clock and reset:
//   0: defaults (W=5, 11010, overlap, CNT_W=8)
//   1: W=4, overlap        2: W=4, non-overlap     3: W=5, CNT_W=2
// Each instance is compared against a reference model that keeps the list of
// accepted bits and tests the pattern directly on that list.
// -----------------------------------------------------------------------------
module tb_pattern_detector_moore;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  logic        v_in[4];
  logic        d_in[4];
  logic        ld_in[4];
  logic [15:0] p_in[4];
  logic        det_o[4];
  logic        busy_o[4];
  logic [7:0]  c0, c1, c2;
  logic [1:0]  c3;
  logic [7:0]  cnt_o[4];

  assign cnt_o[0] = c0;
  assign cnt_o[1] = c1;
  assign cnt_o[2] = c2;
  assign cnt_o[3] = {6'd0, c3};

  pattern_detector_moore u_def (
    .clk_in(clk), .reset(reset), .data_valid_in(v_in[0]), .data_in(d_in[0]),
    .load_in(ld_in[0]), .pattern_in(p_in[0][4:0]), .detected_out(det_o[0]),
    .match_count_out(c0), .busy_out(busy_o[0]));

  pattern_detector_moore #(.PATTERN_W(4), .PATTERN_RST(4'b1100), .OVERLAP(1)) u_ov1 (
    .clk_in(clk), .reset(reset), .data_valid_in(v_in[1]), .data_in(d_in[1]),
    .load_in(ld_in[1]), .pattern_in(p_in[1][3:0]), .detected_out(det_o[1]),
    .match_count_out(c1), .busy_out(busy_o[1]));

  pattern_detector_moore #(.PATTERN_W(4), .PATTERN_RST(4'b1100), .OVERLAP(0)) u_ov0 (
    .clk_in(clk), .reset(reset), .data_valid_in(v_in[2]), .data_in(d_in[2]),
    .load_in(ld_in[2]), .pattern_in(p_in[2][3:0]), .detected_out(det_o[2]),
    .match_count_out(c2), .busy_out(busy_o[2]));

  pattern_detector_moore #(.CNT_W(2)) u_sat (
    .clk_in(clk), .reset(reset), .data_valid_in(v_in[3]), .data_in(d_in[3]),
    .load_in(ld_in[3]), .pattern_in(p_in[3][4:0]), .detected_out(det_o[3]),
    .match_count_out(c3), .busy_out(busy_o[3]));

  // ---------------- reference model ----------------
  int          m_w[4]   = '{5, 4, 4, 5};
  int          m_ov[4]  = '{1, 1, 0, 1};
  int          m_max[4] = '{255, 255, 255, 3};
  logic [15:0] m_rst[4] = '{16'h1A, 16'hC, 16'hC, 16'h1A};
  bit          m_q[4][$];   // accepted bits, oldest first, last W kept
  logic [15:0] m_pat[4];
  int          m_cnt[4];
  bit          m_det[4];

  int tests = 0;
  int fails = 0;

  // Longest k such that the last k accepted bits equal the first k pattern bits.
  function automatic int model_match(int i);
    int n;
    bit ok;
    n = m_q[i].size();
    for (int k = n; k >= 1; k--) begin
      ok = 1'b1;
      for (int j = 0; j < k; j++)
        if (m_q[i][n-k+j] != m_pat[i][m_w[i]-1-j]) ok = 1'b0;
      if (ok) return k;
    end
    return 0;
  endfunction

  function automatic bit exp_busy(int i);
    return !m_det[i] && (model_match(i) > 0);
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 4; i++) begin
      m_q[i].delete();
      m_pat[i] = m_rst[i];
      m_cnt[i] = 0;
      m_det[i] = 1'b0;
    end
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      model_reset();
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (ld_in[i]) begin
          m_q[i].delete();
          m_pat[i] = p_in[i];
          m_det[i] = 1'b0;
        end else if (v_in[i]) begin
          m_q[i].push_back(d_in[i]);
          if (m_q[i].size() > m_w[i]) void'(m_q[i].pop_front());
          m_det[i] = (m_q[i].size() == m_w[i]) && (model_match(i) == m_w[i]);
          if (m_det[i]) begin
            if (m_cnt[i] < m_max[i]) m_cnt[i]++;
            if (m_ov[i] == 0) m_q[i].delete();
          end
        end else begin
          m_det[i] = 1'b0;
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic drive(input int i, input logic v, input logic d, input logic ld,
                       input logic [15:0] p);
    v_in[i] = v; d_in[i] = d; ld_in[i] = ld; p_in[i] = p;
    @(posedge clk); #1;
    v_in[i] = 1'b0; ld_in[i] = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #3;
    for (int j = 0; j < 4; j++) begin
      tests++; if (det_o[j] !== 1'b0) begin fails++; $display("FAIL reset_det[%0d]: got %b expected 0", j, det_o[j]); end
      tests++; if (busy_o[j] !== 1'b0) begin fails++; $display("FAIL reset_busy[%0d]: got %b expected 0", j, busy_o[j]); end
      tests++; if (cnt_o[j] !== 8'd0) begin fails++; $display("FAIL reset_cnt[%0d]: got %0d expected 0", j, cnt_o[j]); end
    end
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_default_stream();
    logic [4:0] bits = 5'b11010;
    for (int k = 4; k >= 0; k--) begin
      drive(0, 1'b1, bits[k], 1'b0, 16'h0);
      tests++; if (det_o[0] !== m_det[0]) begin fails++; $display("FAIL stream_det bit%0d: got %b expected %b", 5-k, det_o[0], m_det[0]); end
      tests++; if (busy_o[0] !== exp_busy(0)) begin fails++; $display("FAIL stream_busy bit%0d: got %b expected %b", 5-k, busy_o[0], exp_busy(0)); end
    end
    tests++; if (det_o[0] !== 1'b1) begin fails++; $display("FAIL stream_hit: got %b expected 1", det_o[0]); end
    drive(0, 1'b0, 1'b0, 1'b0, 16'h0);
    tests++; if (det_o[0] !== 1'b0) begin fails++; $display("FAIL stream_one_cycle: got %b expected 0", det_o[0]); end
    tests++; if (cnt_o[0] !== 8'd1) begin fails++; $display("FAIL stream_cnt: got %0d expected 1", cnt_o[0]); end
  endtask

  task automatic test_valid_gaps();
    logic [4:0] bits = 5'b11010;
    int pulses = 0;
    for (int k = 4; k >= 0; k--) begin
      drive(0, 1'b1, bits[k], 1'b0, 16'h0);
      if (det_o[0] === 1'b1) pulses++;
      tests++; if (det_o[0] !== m_det[0]) begin fails++; $display("FAIL gaps_det bit%0d: got %b expected %b", 5-k, det_o[0], m_det[0]); end
      if (k != 0) begin
        for (int g = 0; g < 3; g++) begin
          drive(0, 1'b0, 1'b1, 1'b0, 16'h0);
          tests++; if (det_o[0] !== 1'b0) begin fails++; $display("FAIL gaps_idle_det: got %b expected 0", det_o[0]); end
          tests++; if (busy_o[0] !== exp_busy(0)) begin fails++; $display("FAIL gaps_busy: got %b expected %b", busy_o[0], exp_busy(0)); end
        end
      end
    end
    tests++; if (pulses != 1) begin fails++; $display("FAIL gaps_pulses: got %0d expected 1", pulses); end
    drive(0, 1'b0, 1'b0, 1'b0, 16'h0);
    tests++; if (cnt_o[0] !== 8'd2) begin fails++; $display("FAIL gaps_cnt: got %0d expected 2", cnt_o[0]); end
  endtask

  task automatic test_load_collision();
    logic [3:0] bits = 4'b1010;
    // A '1' captured with the load would complete 11010 after the next 4 bits.
    drive(0, 1'b1, 1'b1, 1'b1, 16'h1A);
    tests++; if (busy_o[0] !== 1'b0) begin fails++; $display("FAIL coll_busy: got %b expected 0", busy_o[0]); end
    tests++; if (cnt_o[0] !== 8'd2) begin fails++; $display("FAIL coll_cnt: got %0d expected 2", cnt_o[0]); end
    for (int k = 3; k >= 0; k--) begin
      drive(0, 1'b1, bits[k], 1'b0, 16'h1A);
      tests++; if (det_o[0] !== 1'b0) begin fails++; $display("FAIL coll_det bit%0d: got %b expected 0", 4-k, det_o[0]); end
      tests++; if (busy_o[0] !== exp_busy(0)) begin fails++; $display("FAIL coll_busy bit%0d: got %b expected %b", 4-k, busy_o[0], exp_busy(0)); end
    end
    tests++; if (cnt_o[0] !== 8'd2) begin fails++; $display("FAIL coll_cnt_end: got %0d expected 2", cnt_o[0]); end
  endtask

  task automatic run_1010(input int i, input int exp_mask, input int exp_cnt, input string name);
    int mask = 0;
    drive(i, 1'b0, 1'b0, 1'b1, 16'hA);
    for (int k = 1; k <= 8; k++) begin
      drive(i, 1'b1, (k % 2 == 1), 1'b0, 16'hA);
      if (det_o[i] === 1'b1) mask |= (1 << k);
      tests++; if (det_o[i] !== m_det[i]) begin fails++; $display("FAIL %s_det bit%0d: got %b expected %b", name, k, det_o[i], m_det[i]); end
      tests++; if (busy_o[i] !== exp_busy(i)) begin fails++; $display("FAIL %s_busy bit%0d: got %b expected %b", name, k, busy_o[i], exp_busy(i)); end
    end
    tests++; if (mask != exp_mask) begin fails++; $display("FAIL %s_hits: got %h expected %h", name, mask, exp_mask); end
    tests++; if (cnt_o[i] !== 8'(exp_cnt)) begin fails++; $display("FAIL %s_cnt: got %0d expected %0d", name, cnt_o[i], exp_cnt); end
  endtask

  task automatic test_overlap();
    run_1010(1, (1 << 4) | (1 << 6) | (1 << 8), 3, "overlap");
  endtask

  task automatic test_non_overlap();
    run_1010(2, (1 << 4) | (1 << 8), 2, "non_overlap");
  endtask

  task automatic test_saturation();
    logic [4:0] bits = 5'b11010;
    for (int r = 0; r < 5; r++) begin
      for (int k = 4; k >= 0; k--) begin
        drive(3, 1'b1, bits[k], 1'b0, 16'h0);
        tests++; if (det_o[3] !== m_det[3]) begin fails++; $display("FAIL sat_det r%0d: got %b expected %b", r, det_o[3], m_det[3]); end
        tests++; if (cnt_o[3] !== 8'(m_cnt[3])) begin fails++; $display("FAIL sat_cnt r%0d: got %0d expected %0d", r, cnt_o[3], m_cnt[3]); end
      end
    end
    tests++; if (cnt_o[3] !== 8'd3) begin fails++; $display("FAIL sat_final: got %0d expected 3", cnt_o[3]); end
  endtask

  task automatic test_reset_mid();
    logic [3:0] bits = 4'b1101;
    for (int k = 3; k >= 0; k--) drive(0, 1'b1, bits[k], 1'b0, 16'h0);
    tests++; if (busy_o[0] !== exp_busy(0)) begin fails++; $display("FAIL mid_busy_pre: got %b expected %b", busy_o[0], exp_busy(0)); end
    #2 reset = 1'b0;
    #1;
    tests++; if (busy_o[0] !== 1'b0) begin fails++; $display("FAIL mid_busy_rst: got %b expected 0", busy_o[0]); end
    tests++; if (cnt_o[0] !== 8'd0) begin fails++; $display("FAIL mid_cnt_rst: got %0d expected 0", cnt_o[0]); end
    @(negedge clk) reset = 1'b1;
    drive(0, 1'b1, 1'b0, 1'b0, 16'h0);
    tests++; if (det_o[0] !== 1'b0) begin fails++; $display("FAIL mid_det: got %b expected 0", det_o[0]); end
    drive(0, 1'b0, 1'b0, 1'b0, 16'h0);
    tests++; if (det_o[0] !== 1'b0) begin fails++; $display("FAIL mid_det2: got %b expected 0", det_o[0]); end
    tests++; if (cnt_o[0] !== 8'd0) begin fails++; $display("FAIL mid_cnt: got %0d expected 0", cnt_o[0]); end
  endtask

  task automatic test_random();
    int i;
    logic [15:0] p;
    for (int c = 0; c < 800; c++) begin
      i = $urandom_range(0, 3);
      p = (($urandom_range(0, 1) == 0) ? m_rst[i] : 16'($urandom)) & 16'((1 << m_w[i]) - 1);
      drive(i, ($urandom_range(0, 3) != 0), 1'($urandom), ($urandom_range(0, 40) == 0), p);
      for (int j = 0; j < 4; j++) begin
        tests++; if (det_o[j] !== m_det[j]) begin fails++; $display("FAIL rand_det[%0d] c%0d: got %b expected %b", j, c, det_o[j], m_det[j]); end
        tests++; if (busy_o[j] !== exp_busy(j)) begin fails++; $display("FAIL rand_busy[%0d] c%0d: got %b expected %b", j, c, busy_o[j], exp_busy(j)); end
        tests++; if (cnt_o[j] !== 8'(m_cnt[j])) begin fails++; $display("FAIL rand_cnt[%0d] c%0d: got %0d expected %0d", j, c, cnt_o[j], m_cnt[j]); end
      end
    end
  endtask

  initial begin
    reset = 1'b0;
    for (int j = 0; j < 4; j++) begin
      v_in[j] = 1'b0; d_in[j] = 1'b0; ld_in[j] = 1'b0; p_in[j] = 16'h0;
    end
    model_reset();
    test_reset();
    test_default_stream();
    test_valid_gaps();
    test_load_collision();
    test_overlap();
    test_non_overlap();
    test_saturation();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
